sm_imem_loader: RTL and testbench

//  Writer side of the schoolMIPS instruction-memory interface. The CPU only reads imem
//  (word address = pc, one 32-bit word per address); this block fills imem's write port.

---
 rtl/sm_imem_loader_pkg.sv | 24 ++
 rtl/sm_imem_loader_timer.sv | 29 ++
 rtl/sm_imem_loader.sv | 166 ++++++++++++++++
 tb/tb_sm_imem_loader.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_imem_loader_pkg.sv
// Shared constants for the imem loader: sync byte, error codes, FSM state encodings.
// No logic here; pure definitions imported by the loader and its timer.
package sm_imem_loader_pkg;

    localparam logic [7:0] LDR_SYNC        = 8'hA5;

    localparam logic [1:0] LDR_ERR_NONE    = 2'd0;
    localparam logic [1:0] LDR_ERR_CSUM    = 2'd1;
    localparam logic [1:0] LDR_ERR_LEN     = 2'd2;
    localparam logic [1:0] LDR_ERR_TIMEOUT = 2'd3;

    localparam logic [2:0] LDR_IDLE   = 3'd0;
    localparam logic [2:0] LDR_LEN0   = 3'd1;
    localparam logic [2:0] LDR_LEN1   = 3'd2;
    localparam logic [2:0] LDR_DATA   = 3'd3;
    localparam logic [2:0] LDR_CSUM   = 3'd4;
    localparam logic [2:0] LDR_FINISH = 3'd5;

    // States in which the inter-byte idle timer is armed.
    function automatic logic ldr_in_frame(input logic [2:0] st);
        return (st == LDR_LEN0) || (st == LDR_LEN1) || (st == LDR_DATA) || (st == LDR_CSUM);
    endfunction

endpackage

// File: rtl/sm_imem_loader_timer.sv
// Idle-cycle counter: counts enabled cycles since last clear, flags when TIMEOUT is reached.
// Expired flag is registered-count based (no extra latency); saturates until cleared.
module sm_imem_loader_timer #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sm_imem_loader.sv
// Framed byte-stream to imem write-port loader; holds the CPU in reset until a good frame lands.
// One imem write the cycle after each 4th data byte; rx_ready drops only in reset and FINISH.
module sm_imem_loader
    import sm_imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 100000,
    parameter bit BOOT_HOLD  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    logic [2:0]            r_state;
    logic                  r_live;
    logic [7:0]            r_sum;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_rem;
    logic [1:0]            r_idx;
    logic [23:0]           r_asm;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [31:0]           r_wr_data;
    logic                  r_cpu_rst_n;
    logic                  r_err;
    logic [1:0]            r_err_code;

    logic        w_take;
    logic        w_in_frame;
    logic        w_expired;
    logic [15:0] w_len;
    logic [31:0] w_word;
    logic [7:0]  w_sum_nxt;

    assign rx_ready   = r_live && (r_state != LDR_FINISH);
    assign w_take     = rx_valid && rx_ready;
    assign w_in_frame = ldr_in_frame(r_state);
    assign w_len      = {rx_data, r_len_lo};
    // Bytes arrive little-endian: the three held bytes form [23:0], the live byte tops the word.
    assign w_word     = {rx_data, r_asm};
    assign w_sum_nxt  = r_sum + rx_data;

    sm_imem_loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_take || !w_in_frame),
        .i_en      (w_in_frame),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LDR_IDLE;
            r_live      <= 1'b0;
            r_sum       <= '0;
            r_len_lo    <= '0;
            r_rem       <= '0;
            r_idx       <= '0;
            r_asm       <= '0;
            r_addr      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cpu_rst_n <= ~BOOT_HOLD;
            r_err       <= 1'b0;
            r_err_code  <= LDR_ERR_NONE;
        end else begin
            r_live  <= 1'b1;
            r_wr_en <= 1'b0;
            case (r_state)
                LDR_IDLE: begin
                    if (w_take && (rx_data == LDR_SYNC)) begin
                        r_state     <= LDR_LEN0;
                        r_cpu_rst_n <= 1'b0;
                        r_err       <= 1'b0;
                        r_err_code  <= LDR_ERR_NONE;
                        r_sum       <= '0;
                        r_addr      <= '0;
                        r_idx       <= '0;
                    end
                end
                LDR_FINISH: begin
                    r_cpu_rst_n <= 1'b1;
                    r_state     <= LDR_IDLE;
                end
                default: begin
                    if (w_take) begin
                        r_sum <= w_sum_nxt;
                        case (r_state)
                            LDR_LEN0: begin
                                r_len_lo <= rx_data;
                                r_state  <= LDR_LEN1;
                            end
                            LDR_LEN1: begin
                                if ({1'b0, w_len} > CAPACITY) begin
                                    r_err      <= 1'b1;
                                    r_err_code <= LDR_ERR_LEN;
                                    r_state    <= LDR_IDLE;
                                end else if (w_len == 16'd0) begin
                                    r_state <= LDR_CSUM;
                                end else begin
                                    r_rem   <= w_len;
                                    r_state <= LDR_DATA;
                                end
                            end
                            LDR_DATA: begin
                                r_asm <= w_word[31:8];
                                r_idx <= r_idx + 2'd1;
                                if (r_idx == 2'd3) begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= r_addr;
                                    r_wr_data <= w_word;
                                    r_addr    <= r_addr + ADDR_WIDTH'(1);
                                    r_rem     <= r_rem - 16'd1;
                                    if (r_rem == 16'd1) begin
                                        r_state <= LDR_CSUM;
                                    end
                                end
                            end
                            LDR_CSUM: begin
                                if (rx_data == r_sum) begin
                                    r_state <= LDR_FINISH;
                                end else begin
                                    r_err      <= 1'b1;
                                    r_err_code <= LDR_ERR_CSUM;
                                    r_state    <= LDR_IDLE;
                                end
                            end
                            default: r_state <= LDR_IDLE;
                        endcase
                    end else if (w_expired) begin
                        r_err      <= 1'b1;
                        r_err_code <= LDR_ERR_TIMEOUT;
                        r_state    <= LDR_IDLE;
                    end
                end
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = (r_state != LDR_IDLE);
    assign done      = (r_state == LDR_FINISH);
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_sm_imem_loader.sv
// Bench for sm_imem_loader: directed vector table, hand-written corner sequences, random frames vs a stream parser.
module tb_sm_imem_loader;

    localparam int AW = 6;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    sm_imem_loader #(
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO),
        .BOOT_HOLD  (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+31:0] wr_log [0:4095];
    int             wr_n   = 0;
    int             done_n = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_n < 4096) wr_log[wr_n] <= {wr_addr, wr_data};
            wr_n <= wr_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called and returns at a negedge; the byte is consumed at the posedge in between.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_ready_stall: got 0, expected 1 within 50 cycles");
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic chk_writes(input string nm, input int base, input int exp_n);
        chk({nm, "_wr_count"}, 64'(wr_n - base), 64'(exp_n));
    endtask

    typedef struct {
        int               len;
        logic [0:11][7:0] b;
        int               n_wr;
        logic [31:0]      w0;
        logic [31:0]      w1;
        int               n_done;
        logic             e;
        logic [1:0]       code;
        logic             cpu;
    } vec_t;

    function automatic vec_t mk(input int len, input logic [0:11][7:0] b, input int n_wr,
                                input logic [31:0] w0, input logic [31:0] w1, input int nd,
                                input logic e, input logic [1:0] code, input logic cpu);
        vec_t v;
        v.len = len; v.b = b; v.n_wr = n_wr; v.w0 = w0; v.w1 = w1;
        v.n_done = nd; v.e = e; v.code = code; v.cpu = cpu;
        return v;
    endfunction

    // Reference: parse a complete byte stream frame by frame.
    logic [7:0]     stream [$];
    logic [AW+31:0] m_wr [$];
    int             m_done;
    logic           m_err;
    logic [1:0]     m_code;
    logic           m_cpu;

    task automatic model_run();
        int          i;
        int          n;
        logic [7:0]  sum;
        logic [31:0] word;
        i = 0;
        m_wr.delete();
        m_done = 0;
        while (i < stream.size()) begin
            i++;
            if (stream[i-1] != 8'hA5) continue;
            m_err = 1'b0; m_code = 2'd0; m_cpu = 1'b0;
            if (i + 2 > stream.size()) break;
            n   = int'({stream[i+1], stream[i]});
            sum = stream[i] + stream[i+1];
            i += 2;
            if (n > (1 << AW)) begin
                m_err = 1'b1; m_code = 2'd2;
                continue;
            end
            for (int w = 0; w < n; w++) begin
                word = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
                sum  = sum + word[7:0] + word[15:8] + word[23:16] + word[31:24];
                m_wr.push_back({AW'(w), word});
                i += 4;
            end
            if (stream[i] == sum) begin
                m_done++; m_cpu = 1'b1;
            end else begin
                m_err = 1'b1; m_code = 2'd1;
            end
            i++;
        end
    endtask

    task automatic gen_frame(input int kind, input int n);
        logic [7:0] sum;
        logic [7:0] d;
        stream.push_back(8'hA5);
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        sum = n[7:0] + n[15:8];
        if (kind == 2) return;
        for (int j = 0; j < 4 * n; j++) begin
            d = 8'($urandom_range(0, 255));
            stream.push_back(d);
            sum = sum + d;
        end
        if (kind == 0) stream.push_back(sum);
        else stream.push_back(sum + 8'($urandom_range(1, 255)));
    endtask

    vec_t vecs [0:4];

    initial begin
        int base;
        int dbase;
        int k;
        int kind;
        int n;
        int nfr;
        int ncmp;
        logic [7:0] junk;

        vecs[0] = mk(12, 96'hA5_02_00_05_00_08_24_00_00_00_00_33, 2, 32'h24080005, 32'h0, 1, 1'b0, 2'd0, 1'b1);
        vecs[1] = mk(12, 96'hA5_02_00_05_00_08_24_00_00_00_00_34, 2, 32'h24080005, 32'h0, 0, 1'b1, 2'd1, 1'b0);
        vecs[2] = mk(3,  96'hA5_41_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 0, 1'b1, 2'd2, 1'b0);
        vecs[3] = mk(5,  96'hA5_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1, 1'b0, 2'd0, 1'b1);
        vecs[4] = mk(8,  96'hA5_01_00_A5_A5_A5_A5_95_00_00_00_00, 1, 32'hA5A5A5A5, 32'h0, 1, 1'b0, 2'd0, 1'b1);

        // Reset values
        idle(3);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_rx_ready", rx_ready, 1);

        // Directed vectors
        for (int v = 0; v < 5; v++) begin
            base  = wr_n;
            dbase = done_n;
            for (int j = 0; j < vecs[v].len; j++) send_byte(vecs[v].b[j]);
            idle(3);
            chk_writes($sformatf("vec%0d", v), base, vecs[v].n_wr);
            ncmp = (wr_n - base < vecs[v].n_wr) ? wr_n - base : vecs[v].n_wr;
            for (int j = 0; j < ncmp; j++) begin
                chk($sformatf("vec%0d_wr%0d_addr", v, j), wr_log[base+j][AW+31:32], j);
                chk($sformatf("vec%0d_wr%0d_data", v, j), wr_log[base+j][31:0], (j == 0) ? vecs[v].w0 : vecs[v].w1);
            end
            chk($sformatf("vec%0d_done", v), done_n - dbase, vecs[v].n_done);
            chk($sformatf("vec%0d_err", v), err, vecs[v].e);
            chk($sformatf("vec%0d_code", v), err_code, vecs[v].code);
            chk($sformatf("vec%0d_cpu", v), cpu_rst_n, vecs[v].cpu);
            chk($sformatf("vec%0d_busy", v), busy, 0);
        end

        // Timeout mid-word, then recovery
        base = wr_n;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        k = 0;
        while (!err && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_err", err, 1);
        chk("timeout_code", err_code, 3);
        chk("timeout_latency_in_16_to_18", (k >= 16 && k <= 18), 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_cpu", cpu_rst_n, 0);
        chk_writes("timeout", base, 0);
        base  = wr_n;
        dbase = done_n;
        send_byte(8'hA5);
        chk("err_clear_on_sync", err, 0);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hAB);
        idle(3);
        chk_writes("recover", base, 1);
        if (wr_n - base >= 1) chk("recover_data", wr_log[base][31:0], 32'h44332211);
        if (wr_n - base >= 1) chk("recover_addr", wr_log[base][AW+31:32], 0);
        chk("recover_done", done_n - dbase, 1);
        chk("recover_cpu", cpu_rst_n, 1);

        // Reset on the same edge as the 4th data byte, source holding data through reset
        base  = wr_n;
        dbase = done_n;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h08);
        rx_valid = 1'b1;
        rx_data  = 8'h24;
        rst_n    = 1'b0;
        idle(1);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rx_ready", rx_ready, 0);
        chk("midrst_cpu", cpu_rst_n, 1);
        chk("midrst_wr_data", wr_data, 0);
        idle(2);
        rst_n = 1'b1;
        send_byte(8'h24);
        idle(2);
        send_byte(8'h13);
        send_byte(8'h00);
        chk_writes("midrst_none", base, 0);
        for (int j = 0; j < 12; j++) send_byte(vecs[0].b[j]);
        idle(3);
        chk_writes("midrst_reload", base, 2);
        if (wr_n - base >= 2) begin
            chk("midrst_wr0_addr", wr_log[base][AW+31:32], 0);
            chk("midrst_wr0_data", wr_log[base][31:0], 32'h24080005);
            chk("midrst_wr1_addr", wr_log[base+1][AW+31:32], 1);
        end
        chk("midrst_done", done_n - dbase, 1);

        // Random frame streams vs reference parser
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        m_err = 1'b0; m_code = 2'd0; m_cpu = 1'b1;
        for (int it = 0; it < 20; it++) begin
            stream.delete();
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                for (int j = 0; j < $urandom_range(0, 2); j++) begin
                    junk = 8'($urandom_range(0, 255));
                    stream.push_back((junk == 8'hA5) ? 8'h5A : junk);
                end
                kind = $urandom_range(0, 9);
                kind = (kind < 6) ? 0 : (kind < 8) ? 1 : 2;
                if (it == 0 && f == 0) begin kind = 0; n = 64; end
                else if (it == 1 && f == 0) begin kind = 2; n = 65; end
                else n = (kind == 2) ? $urandom_range(65, 400) : $urandom_range(0, 6);
                gen_frame(kind, n);
            end
            base  = wr_n;
            dbase = done_n;
            foreach (stream[j]) begin
                idle($urandom_range(0, 2));
                send_byte(stream[j]);
            end
            idle(4);
            model_run();
            chk($sformatf("rnd%0d_wr_count", it), wr_n - base, m_wr.size());
            ncmp = (wr_n - base < m_wr.size()) ? wr_n - base : m_wr.size();
            for (int j = 0; j < ncmp; j++) chk($sformatf("rnd%0d_wr%0d", it, j), wr_log[base+j], m_wr[j]);
            chk($sformatf("rnd%0d_done", it), done_n - dbase, m_done);
            chk($sformatf("rnd%0d_err", it), err, m_err);
            chk($sformatf("rnd%0d_code", it), err_code, m_code);
            chk($sformatf("rnd%0d_cpu", it), cpu_rst_n, m_cpu);
            chk($sformatf("rnd%0d_busy", it), busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
